// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared N-to-1 mux.
// Each grant lasts until the owner drops req, pulses release, or reaches MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  // "release" is a reserved word, so the owner's give-up pulse carries this name
  input  logic            release_pulse,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            busy
);

  localparam int unsigned HCW = 8;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [HCW-1:0]  hcnt;

  logic [SELW-1:0] owner_next_c;
  logic [SELW-1:0] base_c;
  logic [N-1:0]    rot_c;
  logic [SELW-1:0] off_c;
  logic [SELW:0]   sum_c;
  logic [SELW-1:0] pick_c;
  logic [N-1:0]    onehot_c;
  logic            found_c;
  logic            end_c;

  // Search from the pointer (or from owner+1 at grant end) for the first requester
  always_comb begin
    owner_next_c = (sel == SELW'(N - 1)) ? '0 : sel + SELW'(1);
    base_c       = (state == OWNED) ? owner_next_c : ptr;
    rot_c        = N'({req, req} >> base_c);
    found_c      = 1'b0;
    off_c        = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_c) begin
        if (rot_c[0]) found_c = 1'b1;
        else          off_c   = off_c + SELW'(1);
      end
      rot_c = rot_c >> 1;
    end
    sum_c = {1'b0, base_c} + {1'b0, off_c};
    if (sum_c >= (SELW + 1)'(N)) sum_c = sum_c - (SELW + 1)'(N);
    pick_c   = sum_c[SELW-1:0];
    onehot_c = {{(N - 1){1'b0}}, 1'b1} << pick_c;
    end_c    = ((req & grant) == '0) || release_pulse || (hcnt == HCW'(MAX_HOLD));
  end

  // Ownership FSM with registered mux controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      hcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            state <= OWNED;
            grant <= onehot_c;
            sel   <= pick_c;
            busy  <= 1'b1;
            hcnt  <= HCW'(1);
          end
        end
        OWNED: begin
          if (end_c) begin
            ptr <= owner_next_c;
            if (found_c) begin
              grant <= onehot_c;
              sel   <= pick_c;
              hcnt  <= HCW'(1);
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end else begin
            hcnt <= hcnt + HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters sharing one ntooneMUX instance.
REQ-002 SHALL have parameter SELW, default 2: select width, equal to log2(N).
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner, legal range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req, input, N: request bit per requester, level-sensitive.
REQ-007 SHALL have port release, input, 1: single-cycle pulse from current owner giving up the resource.
REQ-008 SHALL have port grant, output, N: one-hot grant, registered.
REQ-009 SHALL have port sel, output, SELW: binary index of owner, drives the ntooneMUX sel port directly, registered.
REQ-010 SHALL have port busy, output, 1: high while a grant is active, registered.

Function
REQ-011 SHALL implement two states: IDLE (grant=0, busy=0) and OWNED (exactly one grant bit set, busy=1).
REQ-012 SHALL keep round-robin pointer ptr (SELW bits): first index searched, ascending with wrap from N-1 to 0.
REQ-013 SHALL, in IDLE with req!=0, grant the first set req bit at or after ptr on the next edge. Latency is 1 cycle from req to grant.
REQ-014 SHALL, in IDLE with req==0, stay in IDLE. sel holds its previous value.
REQ-015 SHALL keep hold counter hcnt: 1 in the first OWNED cycle of every grant, +1 per OWNED cycle.
REQ-016 SHALL end the grant in the cycle where any of these holds: req[owner]==0, release==1, or hcnt==MAX_HOLD.
REQ-017 SHALL, at grant end, set ptr=(owner+1) mod N, then re-arbitrate in that same cycle with the updated ptr against current req.
REQ-018 SHALL, at grant end, give the new grant on the next edge with no idle gap. hcnt restarts at 1, including when the same owner is re-granted.
REQ-019 SHALL consider the previous owner last at grant end, so a still-requesting owner is re-granted only if no other req bit is set.
REQ-020 SHALL enter IDLE at grant end if no req bit is set.
REQ-021 SHALL ignore non-owner req changes while OWNED, except during the end-cycle arbitration.
REQ-022 SHALL ignore release in IDLE.
REQ-023 SHALL keep sel equal to the index of the set grant bit whenever busy=1.
REQ-024 SHALL never assert more than one grant bit, and SHALL never set a grant bit whose req bit was 0 in the arbitration cycle.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force grant=0, sel=0, busy=0, ptr=0, hcnt=0, state=IDLE, regardless of req or release.
REQ-026 SHALL abort any active grant on reset, with no partial handoff. Arbitration resumes on the first edge with rst=0.

Verification (N=4, SELW=2, MAX_HOLD=4)
REQ-027 SHALL cover reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, sel=0, busy=0. Then rst=0 -> next edge grant=4'b0001, sel=0, busy=1.
REQ-028 SHALL cover round-robin with timeout: req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles, sel 0,1,2,3,0, busy continuously 1.
REQ-029 SHALL cover a sole requester: req=4'b0100 held 10 cycles -> grant=0100, sel=2 continuously, with hcnt restarting at 1 after cycle 4 and cycle 8.
REQ-030 SHALL cover release: req=4'b0011, owner 0, release pulse in 2nd grant cycle -> next edge grant=0010, sel=1.
REQ-031 SHALL cover req drop: owner 1 drops req with req otherwise 0 -> next edge grant=0, busy=0, sel stays 1. Then req=4'b0001 -> grant=0001 after 1 cycle (ptr=2 wraps to 0).
REQ-032 SHALL cover mid-grant reset: rst=1 for 1 cycle during owner 2's 3rd cycle with req=4'b1100 -> outputs cleared. After release of rst, grant=0100 (ptr=0 search).
